reg_file: RTL and testbench

- 32-entry general-purpose register file for the single-cycle MIPS datapath, directly upstream of the ALU.
- Two combinational read ports produce the ALU A operand and the rt value. The rt value feeds the ALU B-operand mux and the store-data path.
- One synchronous write port takes the write-back result: ALU result, load data or link address.
- Register 0 is hardwired to zero. $sp and $gp take programmable reset values.

---
 rtl/reg_file.sv | 55 +++++
 tb/tb_reg_file.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32-entry MIPS register file: two combinational read ports with optional write-through, one edge-triggered write port.
// Reads are zero latency, writes land on the rising edge; no backpressure, a write is accepted every enabled cycle.
module reg_file #(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 5,
   parameter int                BYPASS  = 1,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
   parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int N_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [N_REGS];
   logic              wr_live;

   function automatic logic [DATA_W-1:0] rst_val(input int idx);
      if (idx == 29)      return SP_INIT;
      else if (idx == 28) return GP_INIT;
      else                return '0;
   endfunction

   // Index 0 is never written, so it holds its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REGS; i++) regs[i] <= rst_val(i);
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Forwarding is suppressed during reset so reads show the reset contents.
   assign wr_live = (BYPASS != 0) && rst_n && wr_en && (wr_addr != '0);

   always_comb begin
      rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
      rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
      if (wr_live && (wr_addr == rd_addr1)) rd_data1 = wr_data;
      if (wr_live && (wr_addr == rd_addr2)) rd_data2 = wr_data;
   end

   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: write-through and stored-value instances driven in parallel from one vector table.
module tb_reg_file;

   localparam logic [31:0] SP = 32'h7FFF_EFFC;
   localparam logic [31:0] GP = 32'h1000_8000;

   logic        clk, rst_n, wr_en;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
   logic [31:0] wr_data;
   logic [31:0] rd1, rd2, dbg, rd1_nb, rd2_nb, dbg_nb;

   reg_file #(.BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd1), .rd_data2(rd2), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg));

   reg_file #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd1_nb), .rd_data2(rd2_nb), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_nb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1, ra2, da;
      logic [31:0] e1, e2, ed, n1, n2;
   } vec_t;

   typedef struct {
      logic [31:0] e1, e2, ed, n1, n2;
   } exp_t;

   vec_t        vecs [14];
   exp_t        sb [$];
   logic [31:0] mdl [32];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] da,
                               input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ed,
                               input logic [31:0] n1, input logic [31:0] n2);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2; v.da = da;
      v.e1 = e1; v.e2 = e2; v.ed = ed; v.n1 = n1; v.n2 = n2;
      return v;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? SP : (i == 28) ? GP : 32'h0;
   endtask

   // Drive one cycle's inputs, queue the expected reads, compare, then let the edge commit.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      rd_addr1 = v.ra1; rd_addr2 = v.ra2; dbg_addr = v.da;
      sb.push_back('{v.e1, v.e2, v.ed, v.n1, v.n2});
      #1;
      e = sb.pop_front();
      chk({tag, ".rd1"},    rd1,    e.e1);
      chk({tag, ".rd2"},    rd2,    e.e2);
      chk({tag, ".dbg"},    dbg,    e.ed);
      chk({tag, ".rd1_nb"}, rd1_nb, e.n1);
      chk({tag, ".rd2_nb"}, rd2_nb, e.n2);
      @(posedge clk);
      if (v.we && v.wa != 5'd0) mdl[v.wa] = v.wd;
   endtask

   initial begin
      vec_t v;
      logic [31:0] byp1, byp2;

      //            we    wa     wd             ra1    ra2    da     e1             e2             ed             n1             n2
      vecs[0]  = mk(1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd9,  5'd8,  32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0,         32'h0);
      vecs[1]  = mk(1'b1, 5'd9,  32'h0000_0005, 5'd8,  5'd9,  5'd9,  32'hDEAD_BEEF, 32'h5,         32'h0,         32'hDEAD_BEEF, 32'h0);
      vecs[2]  = mk(1'b0, 5'd0,  32'h0,         5'd8,  5'd9,  5'd8,  32'hDEAD_BEEF, 32'h5,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h5);
      vecs[3]  = mk(1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0);
      vecs[4]  = mk(1'b0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0);
      vecs[5]  = mk(1'b1, 5'd10, 32'h1111_1111, 5'd10, 5'd29, 5'd10, 32'h1111_1111, SP,            32'h0,         32'h0,         SP);
      vecs[6]  = mk(1'b1, 5'd10, 32'h2222_2222, 5'd10, 5'd10, 5'd10, 32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111);
      vecs[7]  = mk(1'b0, 5'd10, 32'h3333_3333, 5'd10, 5'd28, 5'd10, 32'h2222_2222, GP,            32'h2222_2222, 32'h2222_2222, GP);
      vecs[8]  = mk(1'b0, 5'd12, 32'hABCD_0000, 5'd12, 5'd12, 5'd12, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0);
      vecs[9]  = vecs[8];
      vecs[10] = vecs[8];
      vecs[11] = mk(1'b0, 5'd0,  32'h0,         5'd12, 5'd9,  5'd12, 32'h0,         32'h5,         32'h0,         32'h0,         32'h5);
      vecs[12] = mk(1'b1, 5'd31, 32'h0000_00FF, 5'd31, 5'd8,  5'd31, 32'hFF,        32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF);
      vecs[13] = mk(1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 5'd31, 32'hFF,        32'hFF,        32'hFF,        32'hFF,        32'hFF);

      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
      #1 rst_n = 1'b0;
      #1 wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'hAAAA_AAAA;
      rd_addr1 = 5'd29; rd_addr2 = 5'd28; dbg_addr = 5'd29;
      #1;
      chk("rst.rd1_sp",    rd1,    SP);
      chk("rst.rd2_gp",    rd2,    GP);
      chk("rst.dbg_sp",    dbg,    SP);
      chk("rst.rd1_nb_sp", rd1_nb, SP);
      #5;
      chk("rst.write_ignored", dbg, SP);
      wr_en = 1'b0;
      #4 rst_n = 1'b1;
      mdl_reset();

      for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted between edges while a write to 31 is pending.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1234_5678;
      rd_addr1 = 5'd31; rd_addr2 = 5'd31; dbg_addr = 5'd31;
      #1;
      chk("mid.byp_rd1",  rd1,    32'h1234_5678);
      chk("mid.nb_rd1",   rd1_nb, 32'hFF);
      #1 rst_n = 1'b0;
      #1;
      chk("mid.rst_dbg",  dbg,    32'h0);
      chk("mid.rst_rd1",  rd1,    32'h0);
      chk("mid.rst_rd2",  rd2,    32'h0);
      @(negedge clk);
      wr_en = 1'b0;
      rst_n = 1'b1;
      #1 chk("mid.after_rst_dbg", dbg, 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1 chk($sformatf("sweep.r%0d", i), dbg, (i == 29) ? SP : (i == 28) ? GP : 32'h0);
      end
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1234_5678; dbg_addr = 5'd31;
      @(posedge clk);
      #1 chk("mid.write_after_rst", dbg, 32'h1234_5678);
      mdl_reset();
      mdl[31] = 32'h1234_5678;

      // Random traffic against a reference array, with frequent read/write index collisions.
      for (int n = 0; n < 40; n++) begin
         v.we  = 1'($urandom_range(0, 1));
         v.wa  = 5'($urandom_range(0, 31));
         v.wd  = $urandom();
         v.ra1 = ($urandom_range(0, 2) == 0) ? v.wa : 5'($urandom_range(0, 31));
         v.ra2 = ($urandom_range(0, 2) == 0) ? v.wa : 5'($urandom_range(0, 31));
         v.da  = ($urandom_range(0, 1) == 0) ? v.wa : 5'($urandom_range(0, 31));
         byp1  = (v.we && v.wa == v.ra1 && v.wa != 5'd0) ? v.wd : mdl[v.ra1];
         byp2  = (v.we && v.wa == v.ra2 && v.wa != 5'd0) ? v.wd : mdl[v.ra2];
         v.e1 = byp1; v.e2 = byp2; v.ed = mdl[v.da];
         v.n1 = mdl[v.ra1]; v.n2 = mdl[v.ra2];
         apply(v, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
